// File: rtl/memoria_datos_ext_if.sv
// Data-memory bus between the MEM stage (master) and memoria_datos_ext (slave).
// Carries load/store requests, the registered load result and the debug read port.
interface memoria_datos_ext_if #(parameter int NBITS = 32);
  logic [NBITS-1:0] alu_direccion;
  logic [NBITS-1:0] dato_registro;
  logic             mem_write;
  logic             mem_read;
  logic [1:0]       size;
  logic             zero_ext;
  logic [NBITS-1:0] dato_leido;
  logic             valid;
  logic             busy;
  logic             misaligned;
  logic [NBITS-1:0] debug_direccion;
  logic [NBITS-1:0] debug_dato;

  modport master (
    output alu_direccion, dato_registro, mem_write, mem_read, size, zero_ext, debug_direccion,
    input  dato_leido, valid, busy, misaligned, debug_dato
  );

  modport slave (
    input  alu_direccion, dato_registro, mem_write, mem_read, size, zero_ext, debug_direccion,
    output dato_leido, valid, busy, misaligned, debug_dato
  );
endinterface

// File: rtl/memoria_datos_ext.sv
// MIPS data memory: byte/half/word loads and stores, registered read, debug port, init sequencer.
// Optional macro DMEM_ALIGN_TRAP_EN: misaligned accesses are suppressed and flagged.
//
// state | meaning
// INIT  | sequencer writes memory[ptr] = ptr, requests ignored, busy high
// RUN   | normal load/store service
module memoria_datos_ext #(
  parameter int NBITS  = 32,
  parameter int CELDAS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  memoria_datos_ext_if.slave   bus
);
  localparam int NB  = NBITS / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = $clog2(CELDAS);
  localparam int SW  = $clog2(NBITS);
  localparam logic [OFF-1:0] HALF_MASK = ~OFF'(1);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    ptr;
  logic             run_en;
  logic [NBITS-1:0] mem [CELDAS];

  logic [AW-1:0]    widx;
  logic [OFF-1:0]   boff, loff;
  logic [1:0]       sz;
  logic             mis, acc_ok, wr_en, rd_en;
  logic [SW-1:0]    sh;
  logic [NBITS-1:0] lane_mask, wdata_sh, rd_word, rd_sh, ld;
  logic             unused_bits;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= (state == INIT) ? ptr + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (ptr == AW'(CELDAS - 1)) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  always_comb begin
    bus.busy = (state == INIT);
    run_en   = (state == RUN);
  end

  assign widx = bus.alu_direccion[OFF+AW-1:OFF];
  assign boff = bus.alu_direccion[OFF-1:0];

  // Size 11 behaves as word; on a 16-bit memory a word is a halfword.
  always_comb begin
    sz = bus.size;
    if (sz == 2'b11) sz = 2'b10;
    if (NBITS == 16 && sz == 2'b10) sz = 2'b01;
  end

  assign mis  = ((sz == 2'b01) && boff[0]) || ((sz == 2'b10) && (boff != '0));
  assign loff = (sz == 2'b00) ? boff : (sz == 2'b01) ? (boff & HALF_MASK) : '0;
  assign sh   = {loff, 3'b000};

  always_comb begin
    case (sz)
      2'b00:   lane_mask = NBITS'(8'hFF) << sh;
      2'b01:   lane_mask = NBITS'(16'hFFFF) << sh;
      default: lane_mask = '1;
    endcase
  end

  assign wdata_sh = bus.dato_registro << sh;
  assign rd_word  = mem[widx];
  assign rd_sh    = rd_word >> sh;

  always_comb begin
    case (sz)
      2'b00:   ld = bus.zero_ext ? NBITS'(rd_sh[7:0])  : NBITS'($signed(rd_sh[7:0]));
      2'b01:   ld = bus.zero_ext ? NBITS'(rd_sh[15:0]) : NBITS'($signed(rd_sh[15:0]));
      default: ld = rd_word;
    endcase
  end

`ifdef DMEM_ALIGN_TRAP_EN
  assign acc_ok      = !mis;
  assign unused_bits = ^{bus.alu_direccion[NBITS-1:OFF+AW], bus.debug_direccion[NBITS-1:AW]};
`else
  // Lane offsets above are already forced aligned, so every access proceeds.
  assign acc_ok      = 1'b1;
  assign unused_bits = ^{bus.alu_direccion[NBITS-1:OFF+AW], bus.debug_direccion[NBITS-1:AW], mis};
`endif

  assign wr_en = run_en & bus.mem_write & acc_ok;
  assign rd_en = run_en & bus.mem_read  & acc_ok;

  always_ff @(posedge i_clk) begin
    if (state == INIT)
      mem[ptr] <= NBITS'(ptr);
    else if (wr_en)
      mem[widx] <= (rd_word & ~lane_mask) | (wdata_sh & lane_mask);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.dato_leido <= '0;
      bus.valid      <= 1'b0;
      bus.misaligned <= 1'b0;
      bus.debug_dato <= '0;
    end else begin
      if (rd_en) bus.dato_leido <= ld;
      bus.valid      <= rd_en;
`ifdef DMEM_ALIGN_TRAP_EN
      bus.misaligned <= run_en & (bus.mem_read | bus.mem_write) & mis;
`else
      bus.misaligned <= 1'b0;
`endif
      bus.debug_dato <= mem[bus.debug_direccion[AW-1:0]];
    end
  end
endmodule
